// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 4-channel TDM receive demux: frame lock, slot tracking, serial-to-parallel.
// Frame layout: sync-marked MSB of ch0, then WIDTH bits per slot for slots 0..3.
module tdm_demux4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_sync,
  output logic [WIDTH-1:0] ch0,
  output logic [WIDTH-1:0] ch1,
  output logic [WIDTH-1:0] ch2,
  output logic [WIDTH-1:0] ch3,
  output logic [1:0]       slot_sel,
  output logic             locked,
  output logic             frame_valid,
  output logic             sync_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [CW-1:0]    bit_cnt, bit_cnt_n;
  logic [1:0]       slot_n;
  logic [WIDTH-1:0] stage0, stage1, stage2;
  logic [WIDTH-1:0] stage0_n, stage1_n, stage2_n;
  logic [WIDTH-1:0] ch0_n, ch1_n, ch2_n, ch3_n;
  logic             frame_valid_n, sync_err_n;

  logic [WIDTH-1:0] sample;
  logic [WIDTH-1:0] fresh;
  logic             frame_start;
  logic             slot_last;

  assign sample      = {sr[WIDTH-2:0], in_bit};
  assign fresh       = {{(WIDTH-1){1'b0}}, in_bit};
  assign frame_start = (bit_cnt == '0) && (slot_sel == 2'd0);
  assign slot_last   = (bit_cnt == LAST_BIT);
  assign locked      = (state == RECV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      sr          <= '0;
      bit_cnt     <= '0;
      slot_sel    <= 2'd0;
      stage0      <= '0;
      stage1      <= '0;
      stage2      <= '0;
      ch0         <= '0;
      ch1         <= '0;
      ch2         <= '0;
      ch3         <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_n;
      sr          <= sr_n;
      bit_cnt     <= bit_cnt_n;
      slot_sel    <= slot_n;
      stage0      <= stage0_n;
      stage1      <= stage1_n;
      stage2      <= stage2_n;
      ch0         <= ch0_n;
      ch1         <= ch1_n;
      ch2         <= ch2_n;
      ch3         <= ch3_n;
      frame_valid <= frame_valid_n;
      sync_err    <= sync_err_n;
    end
  end

  always_comb begin
    state_n       = state;
    sr_n          = sr;
    bit_cnt_n     = bit_cnt;
    slot_n        = slot_sel;
    stage0_n      = stage0;
    stage1_n      = stage1;
    stage2_n      = stage2;
    ch0_n         = ch0;
    ch1_n         = ch1;
    ch2_n         = ch2;
    ch3_n         = ch3;
    frame_valid_n = 1'b0;
    sync_err_n    = 1'b0;

    if (in_valid) begin
      case (state)
        HUNT: begin
          if (in_sync) begin
            state_n   = RECV;
            sr_n      = fresh;
            bit_cnt_n = CW'(1);
            slot_n    = 2'd0;
          end
        end

        RECV: begin
          if (frame_start && !in_sync) begin
            // Marker missing where a frame must begin: drop lock and rehunt.
            sync_err_n = 1'b1;
            state_n    = HUNT;
            slot_n     = 2'd0;
            bit_cnt_n  = '0;
          end else if (in_sync && !frame_start) begin
            // Marker mid-frame: abandon the partial frame and restart on this bit.
            sync_err_n = 1'b1;
            sr_n       = fresh;
            bit_cnt_n  = CW'(1);
            slot_n     = 2'd0;
          end else begin
            sr_n = sample;
            if (slot_last) begin
              bit_cnt_n = '0;
              slot_n    = slot_sel + 2'd1;
              case (slot_sel)
                2'd0: stage0_n = sample;
                2'd1: stage1_n = sample;
                2'd2: stage2_n = sample;
                default: begin
                  ch0_n         = stage0;
                  ch1_n         = stage1;
                  ch2_n         = stage2;
                  ch3_n         = sample;
                  frame_valid_n = 1'b1;
                end
              endcase
            end else begin
              bit_cnt_n = bit_cnt + CW'(1);
            end
          end
        end

        default: state_n = HUNT;
      endcase
    end
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive end of the team's 4-channel time-division link. The transmit side walks a 2-bit select through a 4:1 mux tree and sends one channel sample per slot, serially, MSB first.
- This block locks to the frame-sync marker, tracks slot and bit position, and deserializes each slot into a per-channel register.
- It presents all four channel samples together once per completed frame, and flags framing errors.

Parameters:
- WIDTH, 4, bits per channel sample. Legal values are 2 to 16.
- Channel count is fixed at 4, so slot_sel is 2 bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  qualifies in_bit/in_sync; a cycle with in_valid=1 is an "accepted bit"
- in_bit  in  1  serial data bit
- in_sync  in  1  marks the accepted bit as the first bit (MSB) of channel 0 of a frame
- ch0  out  WIDTH  last completed channel-0 sample
- ch1  out  WIDTH  last completed channel-1 sample
- ch2  out  WIDTH  last completed channel-2 sample
- ch3  out  WIDTH  last completed channel-3 sample
- slot_sel  out  2  slot index the next accepted bit belongs to
- locked  out  1  1 while in RECV state
- frame_valid  out  1  one-cycle pulse; ch0..ch3 updated on the same edge
- sync_err  out  1  one-cycle pulse on a framing error

Behaviour:
- Reset, asynchronous and effective immediately on rst_n=0:
  - ch0..ch3=0, slot_sel=0, locked=0, frame_valid=0, sync_err=0.
  - Shift register, staging registers and bit counter cleared; state=HUNT.
  - Reset mid-frame discards the partial frame.
- in_valid=0 cycles: all state holds. in_bit and in_sync are ignored. Pulses are still only one cycle wide.
- HUNT state:
  - Accepted bits with in_sync=0 are discarded.
  - An accepted bit with in_sync=1 is shifted in; bit_cnt=1, slot_sel=0, state goes to RECV, locked=1.
- RECV state, per accepted bit:
  - Shift: sr <= {sr[WIDTH-2:0], in_bit}, MSB first; bit_cnt increments.
  - Last bit of a slot (bit_cnt==WIDTH-1): the completed sample {sr[WIDTH-2:0], in_bit} goes to stage[slot_sel]. slot_sel increments, wrapping 3 to 0, and bit_cnt goes to 0.
  - Last bit of slot 3: on that edge ch0..ch2 <= stage[0..2] and ch3 <= completed sample. frame_valid=1 for exactly the following cycle. slot_sel wraps to 0.
  - Latency: outputs change on the edge that accepts the 4*WIDTH-th bit.
- Sync checking in RECV:
  - Frame start is bit_cnt==0 and slot_sel==0.
  - At frame start with in_sync=1: normal continuation.
  - At frame start with in_sync=0: sync_err pulses; the bit is discarded; locked=0; state goes to HUNT; slot_sel=0.
  - in_sync=1 at any other position: sync_err pulses and the partial frame is discarded (no frame_valid). The bit is taken as a new frame start: sr holds that bit, bit_cnt=1, slot_sel=0, and the block stays in RECV.
- ch0..ch3 hold the last good frame and are never cleared by sync errors. Only reset clears them.
- frame_valid and sync_err are never asserted in the same cycle.

Test Plan:
- Reset: assert rst_n=0 mid-traffic -> immediately ch0..ch3=0, locked=0, slot_sel=0, no pulses. After release, bits without sync are ignored (locked stays 0).
- Clean frame, WIDTH=4:
  - Stimulus: in_valid=1 continuously; bits 1010 0011 1111 0001 with in_sync on the first bit.
  - Response: on the 16th edge ch0=0xA, ch1=0x3, ch2=0xF, ch3=0x1. frame_valid is high for one cycle. slot_sel sequence is 0,1,2,3,0 at bits 4/8/12/16.
- Gapped input: same frame with in_valid low on alternate cycles -> identical outputs; frame_valid follows the 16th accepted bit; state frozen during gaps.
- Early sync:
  - Stimulus: in_sync=1 on accepted bit 6 of a frame.
  - Response: sync_err pulse, no frame_valid, ch unchanged, locked stays 1. A full frame starting at bit 6 completes 15 accepted bits later with correct values.
- Missing sync:
  - Stimulus: second frame's first bit arrives with in_sync=0.
  - Response: sync_err pulse, locked=0, following bits ignored, ch still holds frame 1. The next in_sync=1 re-locks.
- Back-to-back frames: two contiguous synced frames (0x1,0x2,0x3,0x4) then (0xC,0xD,0xE,0xF) -> two frame_valid pulses exactly 16 cycles apart, with the second set of values on the second pulse.
